// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS control unit.
//   - estado_t   : FSM state codes (also driven out on the 'estado' port)
//   - OP_*       : primary opcodes (IR[31:26])
//   - ALUOP_*    : aluOp encodings consumed by ula_controle
//   - PCF_*      : pc_fonte mux selects
//   - ULAB_*     : ula_fonte_b mux selects
// Optional feature macro: MIPS_ADDI_EN (adds the ADDI_EXEC/ADDI_ESCR states).
package mips_pkg;

    typedef enum logic [3:0] {
        BUSCA        = 4'd0,
        DECOD        = 4'd1,
        END_MEM      = 4'd2,
        LE_MEM       = 4'd3,
        ESCR_REG_MEM = 4'd4,
        ESCR_MEM     = 4'd5,
        EXEC         = 4'd6,
        ESCR_R       = 4'd7,
        DESVIO       = 4'd8,
        SALTO        = 4'd9,
`ifdef MIPS_ADDI_EN
        ADDI_EXEC    = 4'd10,
        ADDI_ESCR    = 4'd11,
`endif
        ERRO         = 4'd12,
        INICIO       = 4'd13
    } estado_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCF_ULA      = 2'b00;
    localparam logic [1:0] PCF_ULASAIDA = 2'b01;
    localparam logic [1:0] PCF_SALTO    = 2'b10;

    localparam logic [1:0] ULAB_REG       = 2'b00;
    localparam logic [1:0] ULAB_QUATRO    = 2'b01;
    localparam logic [1:0] ULAB_IMED      = 2'b10;
    localparam logic [1:0] ULAB_IMED_DESL = 2'b11;

    // States that wait on the memory handshake and are covered by the watchdog.
    function automatic logic estado_mem(estado_t e);
        return (e == BUSCA) || (e == LE_MEM) || (e == ESCR_MEM);
    endfunction

endpackage

// File: rtl/uc_decod_saida.sv
// uc_decod_saida: combinational output decoder of the multicycle control FSM.
// Inputs : estado (registered state), mem_pronta (memory handshake).
// Outputs: every datapath enable/select plus excecao. All outputs are 0 unless
//          the state sets them; only BUSCA looks at mem_pronta.
// Optional feature macro: MIPS_ADDI_EN (decodes the ADDI states).
module uc_decod_saida
    import mips_pkg::*;
(
    input  estado_t    estado,
    input  logic       mem_pronta,
    output logic       pc_escreve,
    output logic       pc_escreve_cond,
    output logic       i_ou_d,
    output logic       mem_le,
    output logic       mem_escreve,
    output logic       mem_para_reg,
    output logic       ir_escreve,
    output logic       reg_escreve,
    output logic       reg_dst,
    output logic       ula_fonte_a,
    output logic [1:0] pc_fonte,
    output logic [1:0] aluOp,
    output logic [1:0] ula_fonte_b,
    output logic       excecao
);

    always_comb begin
        pc_escreve      = 1'b0;
        pc_escreve_cond = 1'b0;
        i_ou_d          = 1'b0;
        mem_le          = 1'b0;
        mem_escreve     = 1'b0;
        mem_para_reg    = 1'b0;
        ir_escreve      = 1'b0;
        reg_escreve     = 1'b0;
        reg_dst         = 1'b0;
        ula_fonte_a     = 1'b0;
        pc_fonte        = PCF_ULA;
        aluOp           = ALUOP_ADD;
        ula_fonte_b     = ULAB_REG;
        excecao         = 1'b0;
        unique case (estado)
            BUSCA: begin
                mem_le      = 1'b1;
                ula_fonte_b = ULAB_QUATRO;
                // IR and PC+4 are latched only in the cycle the fetch completes.
                ir_escreve  = mem_pronta;
                pc_escreve  = mem_pronta;
            end
            DECOD: ula_fonte_b = ULAB_IMED_DESL;
            END_MEM: begin
                ula_fonte_a = 1'b1;
                ula_fonte_b = ULAB_IMED;
            end
            LE_MEM: begin
                mem_le = 1'b1;
                i_ou_d = 1'b1;
            end
            ESCR_REG_MEM: begin
                reg_escreve  = 1'b1;
                mem_para_reg = 1'b1;
            end
            ESCR_MEM: begin
                mem_escreve = 1'b1;
                i_ou_d      = 1'b1;
            end
            EXEC: begin
                ula_fonte_a = 1'b1;
                aluOp       = ALUOP_FUNCT;
            end
            ESCR_R: begin
                reg_escreve = 1'b1;
                reg_dst     = 1'b1;
            end
            DESVIO: begin
                ula_fonte_a     = 1'b1;
                aluOp           = ALUOP_SUB;
                pc_escreve_cond = 1'b1;
                pc_fonte        = PCF_ULASAIDA;
            end
            SALTO: begin
                pc_escreve = 1'b1;
                pc_fonte   = PCF_SALTO;
            end
`ifdef MIPS_ADDI_EN
            ADDI_EXEC: begin
                ula_fonte_a = 1'b1;
                ula_fonte_b = ULAB_IMED;
            end
            ADDI_ESCR: reg_escreve = 1'b1;
`endif
            ERRO: excecao = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle main control FSM of the MIPS datapath.
// Parameter: ESPERA_MAX (>=1) max consecutive stall cycles in a memory state.
// Inputs : clk, rst_n (async, active low), opcode (IR[31:26]), mem_pronta.
// Outputs: datapath enables/selects, aluOp, instr_fim (last cycle of an
//          instruction), excecao (pulse in ERRO), estado (current state code).
// Optional feature macro: MIPS_ADDI_EN (opcode 001000 executes as addi).
module unidade_controle_multiciclo
    import mips_pkg::*;
#(
    parameter int unsigned ESPERA_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_pronta,
    output logic       pc_escreve,
    output logic       pc_escreve_cond,
    output logic       i_ou_d,
    output logic       mem_le,
    output logic       mem_escreve,
    output logic       mem_para_reg,
    output logic       ir_escreve,
    output logic       reg_escreve,
    output logic       reg_dst,
    output logic       ula_fonte_a,
    output logic [1:0] pc_fonte,
    output logic [1:0] aluOp,
    output logic [1:0] ula_fonte_b,
    output logic       instr_fim,
    output logic       excecao,
    output logic [3:0] estado
);

    localparam int unsigned CW = $clog2(ESPERA_MAX + 1);

    estado_t          estado_q, estado_d;
    logic    [CW-1:0] cnt_q, cnt_d;
    logic             estouro;

    assign estouro = (cnt_q == CW'(ESPERA_MAX));

    // State register and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= INICIO;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic and watchdog update.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA: begin
                // A completing access wins over a simultaneous timeout.
                if (mem_pronta)   estado_d = DECOD;
                else if (estouro) estado_d = ERRO;
            end
            DECOD: begin
                case (opcode)
                    OP_R:         estado_d = EXEC;
                    OP_LW, OP_SW: estado_d = END_MEM;
                    OP_BEQ:       estado_d = DESVIO;
                    OP_J:         estado_d = SALTO;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      estado_d = ADDI_EXEC;
`endif
                    default:      estado_d = ERRO;
                endcase
            end
            END_MEM: begin
                if (opcode == OP_LW)      estado_d = LE_MEM;
                else if (opcode == OP_SW) estado_d = ESCR_MEM;
                else                      estado_d = ERRO;
            end
            LE_MEM: begin
                if (mem_pronta)   estado_d = ESCR_REG_MEM;
                else if (estouro) estado_d = ERRO;
            end
            ESCR_MEM: begin
                if (mem_pronta)   estado_d = BUSCA;
                else if (estouro) estado_d = ERRO;
            end
            ESCR_REG_MEM: estado_d = BUSCA;
            EXEC:         estado_d = ESCR_R;
            ESCR_R:       estado_d = BUSCA;
            DESVIO:       estado_d = BUSCA;
            SALTO:        estado_d = BUSCA;
`ifdef MIPS_ADDI_EN
            ADDI_EXEC:    estado_d = ADDI_ESCR;
            ADDI_ESCR:    estado_d = BUSCA;
`endif
            ERRO:         estado_d = BUSCA;
            default:      estado_d = INICIO;
        endcase

        cnt_d = cnt_q;
        if (estado_d != estado_q) begin
            cnt_d = '0;
        end else if (estado_mem(estado_q) && !mem_pronta) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Output decode.
    uc_decod_saida u_decod_saida (
        .estado          (estado_q),
        .mem_pronta      (mem_pronta),
        .pc_escreve      (pc_escreve),
        .pc_escreve_cond (pc_escreve_cond),
        .i_ou_d          (i_ou_d),
        .mem_le          (mem_le),
        .mem_escreve     (mem_escreve),
        .mem_para_reg    (mem_para_reg),
        .ir_escreve      (ir_escreve),
        .reg_escreve     (reg_escreve),
        .reg_dst         (reg_dst),
        .ula_fonte_a     (ula_fonte_a),
        .pc_fonte        (pc_fonte),
        .aluOp           (aluOp),
        .ula_fonte_b     (ula_fonte_b),
        .excecao         (excecao)
    );

    // Last cycle of an instruction: about to enter BUSCA from any other state
    // except INICIO (staying in BUSCA during a stall is not an entry).
    always_comb begin
        instr_fim = (estado_d == BUSCA) && (estado_q != BUSCA) && (estado_q != INICIO);
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed, table-driven bench for unidade_controle_multiciclo (ESPERA_MAX=4).
// Optional feature macro: MIPS_ADDI_EN (selects the expected addi sequence).
module tb_unidade_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_pronta;
    logic       pc_escreve, pc_escreve_cond, i_ou_d, mem_le, mem_escreve, mem_para_reg;
    logic       ir_escreve, reg_escreve, reg_dst, ula_fonte_a, instr_fim, excecao;
    logic [1:0] pc_fonte, aluOp, ula_fonte_b;
    logic [3:0] estado;
    logic [17:0] ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(.ESPERA_MAX(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .mem_pronta      (mem_pronta),
        .pc_escreve      (pc_escreve),
        .pc_escreve_cond (pc_escreve_cond),
        .i_ou_d          (i_ou_d),
        .mem_le          (mem_le),
        .mem_escreve     (mem_escreve),
        .mem_para_reg    (mem_para_reg),
        .ir_escreve      (ir_escreve),
        .reg_escreve     (reg_escreve),
        .reg_dst         (reg_dst),
        .ula_fonte_a     (ula_fonte_a),
        .pc_fonte        (pc_fonte),
        .aluOp           (aluOp),
        .ula_fonte_b     (ula_fonte_b),
        .instr_fim       (instr_fim),
        .excecao         (excecao),
        .estado          (estado)
    );

    // {pc_escreve, pc_escreve_cond, i_ou_d, mem_le, mem_escreve, mem_para_reg,
    //  ir_escreve, reg_escreve, reg_dst, ula_fonte_a, pc_fonte, aluOp,
    //  ula_fonte_b, instr_fim, excecao}
    assign ctl = {pc_escreve, pc_escreve_cond, i_ou_d, mem_le, mem_escreve, mem_para_reg,
                  ir_escreve, reg_escreve, reg_dst, ula_fonte_a, pc_fonte, aluOp,
                  ula_fonte_b, instr_fim, excecao};

    localparam logic [17:0] C_ZERO     = 18'b0;
    localparam logic [17:0] C_BUSCA_P  = 18'b1_0_0_1_0_0_1_0_0_0_00_00_01_0_0;
    localparam logic [17:0] C_BUSCA_W  = 18'b0_0_0_1_0_0_0_0_0_0_00_00_01_0_0;
    localparam logic [17:0] C_DECOD    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_11_0_0;
    localparam logic [17:0] C_END_MEM  = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
    localparam logic [17:0] C_LE_MEM   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_ESCR_RM  = 18'b0_0_0_0_0_1_0_1_0_0_00_00_00_1_0;
    localparam logic [17:0] C_ESCR_MF  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] C_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] C_ESCR_R   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] C_DESVIO   = 18'b0_1_0_0_0_0_0_0_0_1_01_01_00_1_0;
    localparam logic [17:0] C_SALTO    = 18'b1_0_0_0_0_0_0_0_0_0_10_00_00_1_0;
    localparam logic [17:0] C_ERRO     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_1;
`ifdef MIPS_ADDI_EN
    localparam logic [17:0] C_ADDI_EX  = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
    localparam logic [17:0] C_ADDI_ES  = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;
`endif

    typedef struct {
        logic [5:0]  op;
        logic        pronta;
        logic [3:0]  est;
        logic [17:0] ctl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] op, input logic pronta, input logic [3:0] est,
                       input logic [17:0] c);
        vec_t v;
        v.op = op; v.pronta = pronta; v.est = est; v.ctl = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nome, input logic [3:0] e_est, input logic [17:0] e_ctl);
        checks++;
        if (estado !== e_est) begin
            errors++;
            $display("FAIL %s estado got %0d expected %0d", nome, estado, e_est);
        end
        checks++;
        if (ctl !== e_ctl) begin
            errors++;
            $display("FAIL %s ctl got %b expected %b", nome, ctl, e_ctl);
        end
    endtask

    task automatic ciclo(input logic [5:0] op, input logic pronta);
        opcode = op;
        mem_pronta = pronta;
        #1;
    endtask

    task automatic avanca();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 6'b000000;
        mem_pronta = 1'b1;

        // R-type right after reset release
        add(6'b000000, 1'b1, 4'd13, C_ZERO);
        add(6'b000000, 1'b1, 4'd0,  C_BUSCA_P);
        add(6'b000000, 1'b1, 4'd1,  C_DECOD);
        add(6'b000000, 1'b1, 4'd6,  C_EXEC);
        add(6'b000000, 1'b1, 4'd7,  C_ESCR_R);
        // lw with three stall cycles in LE_MEM
        add(6'b100011, 1'b1, 4'd0,  C_BUSCA_P);
        add(6'b100011, 1'b1, 4'd1,  C_DECOD);
        add(6'b100011, 1'b1, 4'd2,  C_END_MEM);
        add(6'b100011, 1'b0, 4'd3,  C_LE_MEM);
        add(6'b100011, 1'b0, 4'd3,  C_LE_MEM);
        add(6'b100011, 1'b0, 4'd3,  C_LE_MEM);
        add(6'b100011, 1'b1, 4'd3,  C_LE_MEM);
        add(6'b100011, 1'b1, 4'd4,  C_ESCR_RM);
        // sw
        add(6'b101011, 1'b1, 4'd0,  C_BUSCA_P);
        add(6'b101011, 1'b1, 4'd1,  C_DECOD);
        add(6'b101011, 1'b1, 4'd2,  C_END_MEM);
        add(6'b101011, 1'b1, 4'd5,  C_ESCR_MF);
        // beq
        add(6'b000100, 1'b1, 4'd0,  C_BUSCA_P);
        add(6'b000100, 1'b1, 4'd1,  C_DECOD);
        add(6'b000100, 1'b1, 4'd8,  C_DESVIO);
        // j
        add(6'b000010, 1'b1, 4'd0,  C_BUSCA_P);
        add(6'b000010, 1'b1, 4'd1,  C_DECOD);
        add(6'b000010, 1'b1, 4'd9,  C_SALTO);
        // invalid opcode
        add(6'b111111, 1'b1, 4'd0,  C_BUSCA_P);
        add(6'b111111, 1'b1, 4'd1,  C_DECOD);
        add(6'b111111, 1'b1, 4'd12, C_ERRO);
        // addi
        add(6'b001000, 1'b1, 4'd0,  C_BUSCA_P);
        add(6'b001000, 1'b1, 4'd1,  C_DECOD);
`ifdef MIPS_ADDI_EN
        add(6'b001000, 1'b1, 4'd10, C_ADDI_EX);
        add(6'b001000, 1'b1, 4'd11, C_ADDI_ES);
`else
        add(6'b001000, 1'b1, 4'd12, C_ERRO);
`endif

        // Reset held across two edges
        avanca();
        avanca();
        chk("reset_hold", 4'd13, C_ZERO);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ciclo(vecs[i].op, vecs[i].pronta);
            chk($sformatf("vec%0d", i), vecs[i].est, vecs[i].ctl);
            avanca();
        end

        // Watchdog: five stalled BUSCA cycles lead to ERRO
        for (int k = 0; k < 5; k++) begin
            ciclo(6'b000000, 1'b0);
            chk($sformatf("wd_busca%0d", k), 4'd0, C_BUSCA_W);
            avanca();
        end
        ciclo(6'b000000, 1'b0);
        chk("wd_erro", 4'd12, C_ERRO);
        avanca();

        // Ready on the fifth cycle wins over the timeout
        for (int k = 0; k < 4; k++) begin
            ciclo(6'b100011, 1'b0);
            chk($sformatf("wd2_busca%0d", k), 4'd0, C_BUSCA_W);
            avanca();
        end
        ciclo(6'b100011, 1'b1);
        chk("wd2_pronta", 4'd0, C_BUSCA_P);
        avanca();
        ciclo(6'b100011, 1'b1);
        chk("wd2_decod", 4'd1, C_DECOD);
        avanca();
        ciclo(6'b100011, 1'b1);
        chk("rst_end_mem", 4'd2, C_END_MEM);
        avanca();

        // Asynchronous reset in the middle of LE_MEM
        ciclo(6'b100011, 1'b0);
        chk("rst_le_mem", 4'd3, C_LE_MEM);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 4'd13, C_ZERO);
        avanca();
        chk("rst_held", 4'd13, C_ZERO);
        rst_n = 1'b1;
        #1;
        chk("rst_inicio", 4'd13, C_ZERO);
        avanca();
        ciclo(6'b000000, 1'b1);
        chk("rst_busca", 4'd0, C_BUSCA_P);
        avanca();
        ciclo(6'b000000, 1'b1);
        chk("rst_decod", 4'd1, C_DECOD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

Multicycle main control FSM for the MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, plus the 2-bit `aluOp` consumed by `ula_controle`. Memory accesses use a ready handshake with a stall watchdog.

## Interface
Parameters:
- `ESPERA_MAX`, default 15: maximum consecutive stall cycles allowed in a memory state. Must be ≥1.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; valid from DECOD onward.
- `mem_pronta`  in  1  memory has completed the current access this cycle.
- `pc_escreve`, `pc_escreve_cond`, `i_ou_d`, `mem_le`, `mem_escreve`, `mem_para_reg`, `ir_escreve`, `reg_escreve`, `reg_dst`, `ula_fonte_a`  out  1 each  datapath controls.
- `pc_fonte`  out  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target.
- `aluOp`  out  2  to `ula_controle`: 00 add, 01 sub, 10 funct.
- `ula_fonte_b`  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm.
- `instr_fim`  out  1  one-cycle pulse on the last cycle of each instruction.
- `excecao`  out  1  one-cycle pulse in ERRO.
- `estado`  out  4  current state code.

## Operation
- Moore outputs are decoded from the registered state. Exception: in BUSCA, `ir_escreve` and `pc_escreve` equal `mem_pronta`.
- Any output not listed for a state is 0.
- States, with their codes, outputs and next state:
  - INICIO (13): all outputs 0. Next: BUSCA.
  - BUSCA (0): `mem_le`=1, `ula_fonte_b`=01. Next: DECOD when `mem_pronta`; otherwise stays.
  - DECOD (1): `ula_fonte_b`=11. Next by opcode: 000000→EXEC, 100011/101011→END_MEM, 000100→DESVIO, 000010→SALTO, 001000→ADDI_EXEC (macro-dependent), any other→ERRO.
  - END_MEM (2): `ula_fonte_a`=1, `ula_fonte_b`=10. Next: LE_MEM for lw, ESCR_MEM for sw.
  - LE_MEM (3): `mem_le`=1, `i_ou_d`=1. Next: ESCR_REG_MEM when `mem_pronta`.
  - ESCR_REG_MEM (4): `reg_escreve`=1, `mem_para_reg`=1. Next: BUSCA.
  - ESCR_MEM (5): `mem_escreve`=1, `i_ou_d`=1. Next: BUSCA when `mem_pronta`.
  - EXEC (6): `ula_fonte_a`=1, `aluOp`=10. Next: ESCR_R.
  - ESCR_R (7): `reg_escreve`=1, `reg_dst`=1. Next: BUSCA.
  - DESVIO (8): `ula_fonte_a`=1, `aluOp`=01, `pc_escreve_cond`=1, `pc_fonte`=01. Next: BUSCA.
  - SALTO (9): `pc_escreve`=1, `pc_fonte`=10. Next: BUSCA.
  - ADDI_EXEC (10): `ula_fonte_a`=1, `ula_fonte_b`=10. Next: ADDI_ESCR.
  - ADDI_ESCR (11): `reg_escreve`=1. Next: BUSCA.
  - ERRO (12): `excecao`=1. Next: BUSCA.
- `instr_fim` = 1 on any transition into BUSCA from a non-INICIO state.
- Watchdog counter:
  - Width $clog2(ESPERA_MAX+1).
  - Increments each cycle in BUSCA, LE_MEM or ESCR_MEM while `mem_pronta`=0.
  - Clears on any state change.
  - When it equals ESPERA_MAX and `mem_pronta`=0, the next state is ERRO.
  - `mem_pronta`=1 in that same cycle takes priority: the access completes normally.
- `mem_le`/`mem_escreve` are held high for the whole wait.

## Timing
- Reset: asserting `rst_n` forces INICIO immediately, mid-instruction included.
  - All outputs drop to 0 asynchronously; the counter clears.
  - After deassertion: one INICIO cycle, then BUSCA.
- Cycles per instruction with `mem_pronta` tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each stall cycle adds 1.
- Invalid opcode: BUSCA, DECOD, ERRO, then BUSCA (3 cycles). `instr_fim` is asserted in ERRO.
- `opcode` is sampled only in DECOD and END_MEM; it must be stable there.

## Configuration
- `MIPS_ADDI_EN` defined: opcode 001000 decodes to ADDI_EXEC→ADDI_ESCR.
- Undefined: 001000 goes to ERRO, and states 10/11 are not generated.

## Structure
- Package `mips_pkg` holds:
  - state codes;
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - `aluOp` constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - `pc_fonte`/`ula_fonte_b` select encodings.
- One sub-module, `uc_decod_saida`: a purely combinational map from state plus `mem_pronta` to the outputs. The top holds the state register, next-state logic and watchdog.

## Test plan
- Reset held, then released with `opcode`=000000 and `mem_pronta`=1 → all outputs 0 during reset; `estado` = 13, 0, 1, 6, 7, 0; `aluOp`=10 in EXEC; `reg_escreve`=`reg_dst`=1 in ESCR_R; one `instr_fim` pulse.
- lw (100011) with `mem_pronta` low for 3 cycles in LE_MEM → `mem_le`=`i_ou_d`=1 for 4 cycles; 8 cycles total; `mem_para_reg`=1 in state 4.
- sw then beq → sw: `mem_escreve`=1 in state 5, 4 cycles. beq: `aluOp`=01, `pc_escreve_cond`=1, `pc_fonte`=01, 3 cycles.
- Opcode 111111, and 001000 with the macro off → `excecao` pulse in state 12, then BUSCA. With the macro on, 001000 gives states 10, 11 and `reg_escreve`=1.
- ESPERA_MAX=4, `mem_pronta` held 0 in BUSCA → ERRO after 5 BUSCA cycles. Repeat with `mem_pronta`=1 on the 5th cycle → DECOD, no `excecao`.
- `rst_n` asserted in LE_MEM → outputs 0 the same cycle; restart through INICIO.
